arp_cache_assoc: RTL and testbench

ARP_CACHE_ASSOC -- requirements
Module: arp_cache_assoc

---
 rtl/arp_cache_assoc.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_arp_cache_assoc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cache_assoc.sv
// ---------------------------------------------------------------------------
// arp_cache_assoc
//
// Set-associative IP -> MAC cache. The set index is the low CACHE_ADDR_WIDTH
// bits of a reflected CRC-32 of the IP address. Each set holds WAYS entries
// of {valid, ip, mac, age}. A small control FSM sweeps the whole array one
// set per cycle, either to invalidate it (CLEAR) or to age every entry by
// one (AGE). Queries and writes each take two cycles through the array and
// may run concurrently.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   query_request_*          valid/ready query channel carrying the IP
//   query_response_*         valid/ready response: error flag + MAC
//   write_request_*          valid/ready insert/refresh channel (IP + MAC)
//   clear_cache              one-cycle pulse, invalidate the whole cache
//   age_tick                 one-cycle pulse, age every entry by one
//   busy                     high while a CLEAR or AGE sweep is running
// ---------------------------------------------------------------------------
module arp_cache_assoc #(
    parameter int CACHE_ADDR_WIDTH = 9,
    parameter int WAYS             = 2,
    parameter int AGE_WIDTH        = 3,
    parameter int MAX_AGE          = 6
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        query_request_valid,
    output logic        query_request_ready,
    input  logic [31:0] query_request_ip,

    output logic        query_response_valid,
    input  logic        query_response_ready,
    output logic        query_response_error,
    output logic [47:0] query_response_mac,

    input  logic        write_request_valid,
    output logic        write_request_ready,
    input  logic [31:0] write_request_ip,
    input  logic [47:0] write_request_mac,

    input  logic        clear_cache,
    input  logic        age_tick,
    output logic        busy
);

    localparam int SETS = 1 << CACHE_ADDR_WIDTH;

    localparam logic [CACHE_ADDR_WIDTH-1:0] LAST_IDX  = '1;
    localparam logic [AGE_WIDTH-1:0]        AGE_SAT   = '1;
    localparam logic [AGE_WIDTH-1:0]        MAX_AGE_V = AGE_WIDTH'(MAX_AGE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_AGE   = 2'd2;

    // Reflected CRC-32 (poly 0x04C11DB7 / 0xEDB88320 reflected), init all
    // ones, no final XOR, data consumed LSB first. Only the index bits are
    // returned since nothing else needs the hash.
    function automatic logic [CACHE_ADDR_WIDTH-1:0] set_index(input logic [31:0] data);
        logic [31:0] crc;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            if (crc[0] ^ data[i]) begin
                crc = (crc >> 1) ^ 32'hEDB8_8320;
            end else begin
                crc = crc >> 1;
            end
        end
        return crc[CACHE_ADDR_WIDTH-1:0];
    endfunction

    // Storage, deliberately without reset: the CLEAR sweep that follows
    // reset is what makes the valid bits meaningful.
    logic                 valid_mem [WAYS][SETS];
    logic [31:0]          ip_mem    [WAYS][SETS];
    logic [47:0]          mac_mem   [WAYS][SETS];
    logic [AGE_WIDTH-1:0] age_mem   [WAYS][SETS];

    // Control FSM
    logic [1:0]                  state_q, state_d;
    logic [CACHE_ADDR_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic                        tick_pending_q, tick_pending_d;
    logic                        start_age;
    logic                        sweep_go;
    logic                        clear_en;
    logic                        age_en;

    // Query pipeline
    logic                        q_accept;
    logic                        q_busy_q;
    logic                        q_s1_q;
    logic                        q_s2_q;
    logic [31:0]                 q_ip_q;
    logic [CACHE_ADDR_WIDTH-1:0] q_idx_q;
    logic [WAYS-1:0]             q_rd_valid_q;
    logic [31:0]                 q_rd_ip_q  [WAYS];
    logic [47:0]                 q_rd_mac_q [WAYS];
    logic [AGE_WIDTH-1:0]        q_rd_age_q [WAYS];
    logic                        q_hit;
    logic [47:0]                 q_hit_mac;
    logic                        resp_valid_q;
    logic                        resp_error_q;
    logic [47:0]                 resp_mac_q;

    // Write pipeline
    logic                        w_accept;
    logic                        wr_s1_q;
    logic                        wr_s2_q;
    logic [31:0]                 wr_ip_q;
    logic [47:0]                 wr_mac_q;
    logic [CACHE_ADDR_WIDTH-1:0] wr_idx_q;
    logic [WAYS-1:0]             wr_rd_valid_q;
    logic [31:0]                 wr_rd_ip_q  [WAYS];
    logic [AGE_WIDTH-1:0]        wr_rd_age_q [WAYS];
    logic [WAYS-1:0]             wr_sel;
    logic [WAYS-1:0]             victim_sel;
    logic [AGE_WIDTH-1:0]        victim_age;
    logic                        wr_found;

    logic                        idle_open;

    // Request channels are only open in IDLE and never in the cycle a clear
    // pulse arrives, so a clear can never race a freshly accepted request.
    assign idle_open           = !rst && (state_q == ST_IDLE) && !clear_cache;
    assign query_request_ready = idle_open && !q_busy_q;
    assign write_request_ready = idle_open && !wr_s1_q && !wr_s2_q;
    assign q_accept            = query_request_valid && query_request_ready;
    assign w_accept            = write_request_valid && write_request_ready;

    assign query_response_valid = resp_valid_q && !rst;
    assign query_response_error = resp_error_q && !rst;
    assign query_response_mac   = rst ? 48'h0 : resp_mac_q;
    assign busy                 = rst || (state_q != ST_IDLE);

    // A sweep only advances when no write sits between its read and its
    // write-back, otherwise the write would commit stale set contents.
    assign sweep_go = (state_q != ST_IDLE) && !wr_s1_q && !wr_s2_q && !rst;
    assign clear_en = sweep_go && (state_q == ST_CLEAR);
    assign age_en   = sweep_go && (state_q == ST_AGE);

    // Next-state logic: a clear pulse restarts the CLEAR sweep from any
    // state (aborting an AGE sweep); an age sweep starts only from IDLE
    // with no write in progress or being accepted.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        start_age   = 1'b0;
        if (clear_cache) begin
            state_d     = ST_CLEAR;
            sweep_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_pending_q && !wr_s1_q && !wr_s2_q && !w_accept) begin
                        state_d     = ST_AGE;
                        sweep_idx_d = '0;
                        start_age   = 1'b1;
                    end
                end
                default: begin
                    if (sweep_go) begin
                        if (sweep_idx_q == LAST_IDX) begin
                            state_d     = ST_IDLE;
                            sweep_idx_d = '0;
                        end else begin
                            sweep_idx_d = sweep_idx_q + CACHE_ADDR_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // One pending tick at most: the flag is consumed when AGE starts, and a
    // tick arriving in that same cycle becomes the next pending one.
    always_comb begin
        tick_pending_d = (tick_pending_q && !start_age) || age_tick;
    end

    // Query hit detection on the registered set snapshot; the lowest way
    // that matches and is not expired wins.
    always_comb begin
        q_hit     = 1'b0;
        q_hit_mac = 48'h0;
        for (int i = 0; i < WAYS; i++) begin
            if (!q_hit && q_rd_valid_q[i] && (q_rd_ip_q[i] == q_ip_q) &&
                (q_rd_age_q[i] < MAX_AGE_V)) begin
                q_hit     = 1'b1;
                q_hit_mac = q_rd_mac_q[i];
            end
        end
    end

    // Write way selection: matching valid entry first, then the lowest
    // invalid way, else the oldest way (lowest index wins ties because only
    // a strictly greater age replaces the current victim).
    always_comb begin
        wr_sel     = '0;
        wr_found   = 1'b0;
        victim_sel = '0;
        victim_sel[0] = 1'b1;
        victim_age = wr_rd_age_q[0];
        for (int i = 0; i < WAYS; i++) begin
            if (!wr_found && wr_rd_valid_q[i] && (wr_rd_ip_q[i] == wr_ip_q)) begin
                wr_sel[i] = 1'b1;
                wr_found  = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!wr_found && !wr_rd_valid_q[i]) begin
                wr_sel[i] = 1'b1;
                wr_found  = 1'b1;
            end
        end
        for (int i = 1; i < WAYS; i++) begin
            if (wr_rd_age_q[i] > victim_age) begin
                victim_sel    = '0;
                victim_sel[i] = 1'b1;
                victim_age    = wr_rd_age_q[i];
            end
        end
        if (!wr_found) begin
            wr_sel = victim_sel;
        end
    end

    // Control and handshake registers. Reset parks the FSM at the start of
    // a CLEAR sweep so the array is initialised before any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_CLEAR;
            sweep_idx_q    <= '0;
            tick_pending_q <= 1'b0;
            q_busy_q       <= 1'b0;
            q_s1_q         <= 1'b0;
            q_s2_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_mac_q     <= 48'h0;
            wr_s1_q        <= 1'b0;
            wr_s2_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            tick_pending_q <= tick_pending_d;
            q_s1_q         <= q_accept;
            q_s2_q         <= q_s1_q;
            wr_s1_q        <= w_accept;
            wr_s2_q        <= wr_s1_q;
            if (q_accept) begin
                q_busy_q <= 1'b1;
            end
            if (q_s2_q) begin
                resp_valid_q <= 1'b1;
                resp_error_q <= !q_hit;
                resp_mac_q   <= q_hit ? q_hit_mac : 48'h0;
            end else if (resp_valid_q && query_response_ready) begin
                resp_valid_q <= 1'b0;
                q_busy_q     <= 1'b0;
            end
        end
    end

    // Datapath: request capture, set snapshots for both pipelines, and all
    // array updates. Sweeps and the write-back never touch the array in the
    // same cycle because sweep_go is held off while a write is in flight.
    always_ff @(posedge clk) begin
        if (q_accept) begin
            q_ip_q  <= query_request_ip;
            q_idx_q <= set_index(query_request_ip);
        end
        if (w_accept) begin
            wr_ip_q  <= write_request_ip;
            wr_mac_q <= write_request_mac;
            wr_idx_q <= set_index(write_request_ip);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (q_s1_q) begin
                q_rd_valid_q[i] <= valid_mem[i][q_idx_q];
                q_rd_ip_q[i]    <= ip_mem[i][q_idx_q];
                q_rd_mac_q[i]   <= mac_mem[i][q_idx_q];
                q_rd_age_q[i]   <= age_mem[i][q_idx_q];
            end
            if (wr_s1_q) begin
                wr_rd_valid_q[i] <= valid_mem[i][wr_idx_q];
                wr_rd_ip_q[i]    <= ip_mem[i][wr_idx_q];
                wr_rd_age_q[i]   <= age_mem[i][wr_idx_q];
            end
            if (clear_en) begin
                valid_mem[i][sweep_idx_q] <= 1'b0;
                age_mem[i][sweep_idx_q]   <= '0;
            end else if (age_en && (age_mem[i][sweep_idx_q] != AGE_SAT)) begin
                age_mem[i][sweep_idx_q] <= age_mem[i][sweep_idx_q] + AGE_WIDTH'(1);
            end
            if (wr_s2_q && wr_sel[i]) begin
                valid_mem[i][wr_idx_q] <= 1'b1;
                ip_mem[i][wr_idx_q]    <= wr_ip_q;
                mac_mem[i][wr_idx_q]   <= wr_mac_q;
                age_mem[i][wr_idx_q]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_arp_cache_assoc.sv
// ---------------------------------------------------------------------------
// tb_arp_cache_assoc
//
// Self-checking bench for arp_cache_assoc with a 16-set, 2-way, 2-bit-age
// configuration. Expected query results are queued when a query is accepted
// and popped when the response handshake completes.
// ---------------------------------------------------------------------------
module tb_arp_cache_assoc;

    localparam int CAW = 4;
    localparam int NW  = 2;
    localparam int AW  = 2;
    localparam int MA  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        query_request_valid = 1'b0;
    logic        query_request_ready;
    logic [31:0] query_request_ip = 32'h0;
    logic        query_response_valid;
    logic        query_response_ready = 1'b0;
    logic        query_response_error;
    logic [47:0] query_response_mac;
    logic        write_request_valid = 1'b0;
    logic        write_request_ready;
    logic [31:0] write_request_ip = 32'h0;
    logic [47:0] write_request_mac = 48'h0;
    logic        clear_cache = 1'b0;
    logic        age_tick = 1'b0;
    logic        busy;

    typedef struct packed {
        logic        err;
        logic [47:0] mac;
    } exp_t;

    exp_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   edgeCount = 0;
    int   acceptEdge = 0;

    logic [31:0] ipA, ipB, ipC;

    arp_cache_assoc #(
        .CACHE_ADDR_WIDTH(CAW),
        .WAYS(NW),
        .AGE_WIDTH(AW),
        .MAX_AGE(MA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .query_request_valid(query_request_valid),
        .query_request_ready(query_request_ready),
        .query_request_ip(query_request_ip),
        .query_response_valid(query_response_valid),
        .query_response_ready(query_response_ready),
        .query_response_error(query_response_error),
        .query_response_mac(query_response_mac),
        .write_request_valid(write_request_valid),
        .write_request_ready(write_request_ready),
        .write_request_ip(write_request_ip),
        .write_request_mac(write_request_mac),
        .clear_cache(clear_cache),
        .age_tick(age_tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Set index model, byte-at-a-time form of the reflected CRC-32
    function automatic logic [3:0] hashIdx(input logic [31:0] ip);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            b = ip[8*k +: 8];
            for (int j = 0; j < 8; j++) begin
                c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c[3:0];
    endfunction

    // Offers a query and/or a write and waits until each is accepted;
    // the expected query result is queued at acceptance.
    task automatic applyStimulus(input logic doQuery, input logic [31:0] qIp, input logic expErr,
                                 input logic [47:0] expMac, input logic doWrite,
                                 input logic [31:0] wIp, input logic [47:0] wMac);
        logic qPend, wPend, qAcc, wAcc;
        int   guard;
        qPend = doQuery;
        wPend = doWrite;
        query_request_valid = qPend;
        query_request_ip    = qIp;
        write_request_valid = wPend;
        write_request_ip    = wIp;
        write_request_mac   = wMac;
        guard = 0;
        while ((qPend || wPend) && guard < 200) begin
            #1;
            qAcc = qPend && query_request_ready;
            wAcc = wPend && write_request_ready;
            @(posedge clk);
            if (qAcc) expQ.push_back('{expErr, expMac});
            @(negedge clk);
            if (qAcc) begin
                qPend = 1'b0;
                query_request_valid = 1'b0;
                acceptEdge = edgeCount;
            end
            if (wAcc) begin
                wPend = 1'b0;
                write_request_valid = 1'b0;
            end
            guard++;
        end
        if (qPend || wPend) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
            query_request_valid = 1'b0;
            write_request_valid = 1'b0;
        end
    endtask

    // Waits for the response, checks latency and stability while stalled,
    // then completes the handshake and compares against the scoreboard.
    task automatic collectResponse(input string tag, input int hold);
        logic        capErr;
        logic [47:0] capMac;
        exp_t        e;
        int          guard;
        guard = 0;
        #1;
        while (!query_response_valid && guard < 30) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!query_response_valid) begin
            checkOutput({tag, "RespTimeout"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, "Latency"}, 64'(edgeCount - acceptEdge), 64'd2);
        capErr = query_response_error;
        capMac = query_response_mac;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            checkOutput({tag, "HoldStable"}, {query_response_valid, query_response_error, query_response_mac},
                        {1'b1, capErr, capMac});
            checkOutput({tag, "HoldQReady"}, 64'(query_request_ready), 64'd0);
        end
        query_response_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        query_response_ready = 1'b0;
        #1;
        checkOutput({tag, "RespDrop"}, 64'(query_response_valid), 64'd0);
        if (expQ.size() == 0) begin
            checkOutput({tag, "ScoreboardEmpty"}, 64'd0, 64'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "Err"}, 64'(capErr), 64'(e.err));
            checkOutput({tag, "Mac"}, 64'(capMac), 64'(e.mac));
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doQuery(input string tag, input logic [31:0] ip, input logic expErr,
                           input logic [47:0] expMac, input int hold);
        applyStimulus(1'b1, ip, expErr, expMac, 1'b0, 32'h0, 48'h0);
        collectResponse(tag, hold);
        idleCycles(1);
    endtask

    task automatic doWrite(input logic [31:0] ip, input logic [47:0] mac);
        applyStimulus(1'b0, 32'h0, 1'b0, 48'h0, 1'b1, ip, mac);
        idleCycles(3);
    endtask

    task automatic pulseTick();
        age_tick = 1'b1;
        @(negedge clk);
        age_tick = 1'b0;
        idleCycles(20);
    endtask

    task automatic clearAndWait();
        int guard;
        clear_cache = 1'b1;
        @(negedge clk);
        clear_cache = 1'b0;
        guard = 0;
        #1;
        while (busy && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (busy) checkOutput("clearTimeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found;
        int busyLen;
        logic [31:0] cand;

        // Three IPs sharing one set, found with the bench hash model
        ipA = 32'h0A00_0164;
        found = 1;
        for (int x = 1; x < 400 && found < 3; x++) begin
            cand = ipA + 32'(x);
            if (hashIdx(cand) == hashIdx(ipA)) begin
                if (found == 1) ipB = cand;
                else ipC = cand;
                found++;
            end
        end

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstQReady", 64'(query_request_ready), 64'd0);
        checkOutput("rstWReady", 64'(write_request_ready), 64'd0);
        checkOutput("rstResp", {query_response_valid, query_response_error, query_response_mac}, 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Readies rise on the 16th cycle after reset release
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("postRstWReady%0d", k), 64'(write_request_ready), 64'(k == 16));
            checkOutput($sformatf("postRstQReady%0d", k), 64'(query_request_ready), 64'(k == 16));
        end
        @(negedge clk);

        // Basic write then hit
        doWrite(32'h0A00_0001, 48'h02_00_00_00_00_01);
        doQuery("hitBasic", 32'h0A00_0001, 1'b0, 48'h02_00_00_00_00_01, 0);

        // Miss with a stalled response
        doQuery("missStall", 32'h0A00_0009, 1'b1, 48'h0, 5);

        // Oldest-way replacement within one set
        clearAndWait();
        doWrite(ipA, 48'hAA_00_00_00_00_0A);
        pulseTick();
        doWrite(ipB, 48'hBB_00_00_00_00_0B);
        doWrite(ipC, 48'hCC_00_00_00_00_0C);
        doQuery("replA", ipA, 1'b1, 48'h0, 0);
        doQuery("replB", ipB, 1'b0, 48'hBB_00_00_00_00_0B, 0);
        doQuery("replC", ipC, 1'b0, 48'hCC_00_00_00_00_0C, 0);

        // Expiry at MAX_AGE and refresh by rewriting
        clearAndWait();
        doWrite(32'h0A00_0205, 48'h12_34_56_78_9A_BC);
        pulseTick();
        pulseTick();
        doQuery("age2Hit", 32'h0A00_0205, 1'b0, 48'h12_34_56_78_9A_BC, 0);
        pulseTick();
        doQuery("age3Miss", 32'h0A00_0205, 1'b1, 48'h0, 0);
        doWrite(32'h0A00_0205, 48'h12_34_56_78_9A_BD);
        doQuery("refreshHit", 32'h0A00_0205, 1'b0, 48'h12_34_56_78_9A_BD, 0);

        // Clear arriving right behind an accepted write
        clearAndWait();
        doWrite(32'h0A00_0301, 48'h00_00_00_00_03_01);
        doWrite(32'h0A00_0302, 48'h00_00_00_00_03_02);
        doQuery("preClearHit", 32'h0A00_0301, 1'b0, 48'h00_00_00_00_03_01, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 48'h0, 1'b1, 32'h0A00_0303, 48'h00_00_00_00_03_03);
        clear_cache = 1'b1;
        @(negedge clk);
        clear_cache = 1'b0;
        #1;
        checkOutput("clrBusyRise", 64'(busy), 64'd1);
        busyLen = 1;
        for (int g = 0; g < 60 && busy; g++) begin
            @(negedge clk);
            #1;
            if (busy) busyLen++;
        end
        checkOutput("clrBusyLen", 64'(busyLen >= 16 && busyLen <= 18), 64'd1);
        checkOutput("clrWReadyBack", 64'(write_request_ready), 64'd1);
        @(negedge clk);
        doQuery("clrMiss1", 32'h0A00_0301, 1'b1, 48'h0, 0);
        doQuery("clrMiss2", 32'h0A00_0302, 1'b1, 48'h0, 0);
        doQuery("clrMiss3", 32'h0A00_0303, 1'b1, 48'h0, 0);

        // Concurrent query and write: the query sees the set before the write
        clearAndWait();
        applyStimulus(1'b1, 32'h0A00_0401, 1'b1, 48'h0, 1'b1, 32'h0A00_0401, 48'h00_00_00_00_04_01);
        collectResponse("concMiss", 0);
        idleCycles(3);
        doQuery("concHit", 32'h0A00_0401, 1'b0, 48'h00_00_00_00_04_01, 0);

        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
